// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: operation codes for the
// arithmetic and logic groups and the group-select values on l.
package alu_pkg;

  // Arithmetic group (l = 0)
  localparam logic [1:0] OP_INC  = 2'b00; // a + cin
  localparam logic [1:0] OP_NEG  = 2'b01; // ~a + 1 + cin
  localparam logic [1:0] OP_ADD  = 2'b10; // a + b + cin
  localparam logic [1:0] OP_INC1 = 2'b11; // a + 1 + cin

  // Logic group (l = 1)
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  // Group select
  localparam logic SEL_ARITH = 1'b0;
  localparam logic SEL_LOGIC = 1'b1;

endpackage

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with carry-in. Produces the sum and the
// carry out of the MSB; with ALU_OVF_EN defined it also exposes the carry
// into the MSB so the top level can form the signed-overflow flag.
module alu_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ALU_OVF_EN
  ,
  output logic             cmsb
`endif
);

`ifdef ALU_OVF_EN
  logic [WIDTH-1:0] low;
  logic [1:0]       high;

  // Split the add at the MSB so the carry into it is visible
  always_comb begin
    low  = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, ci};
    cmsb = low[WIDTH-1];
    high = {1'b0, x[WIDTH-1]} + {1'b0, y[WIDTH-1]} + {1'b0, cmsb};
    sum  = {high[0], low[WIDTH-2:0]};
    cout = high[1];
  end
`else
  // Plain WIDTH+1 bit sum; the top bit is the carry out
  always_comb begin
    {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  end
`endif

endmodule

// File: rtl/alu_core.sv
// Registered WIDTH-bit ALU (execute stage): four arithmetic ops with
// carry-in, four logic ops, and Z/C/S flags, one cycle of latency.
// Optional feature macro ALU_OVF_EN adds the signed-overflow output v.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             l,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             s
`ifdef ALU_OVF_EN
  ,
  output logic             v
`endif
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic zero_flag(input logic [WIDTH-1:0] val);
    return (val == '0);
  endfunction

  function automatic logic sign_flag(input logic [WIDTH-1:0] val);
    return val[WIDTH-1];
  endfunction

  logic [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0] y_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] logic_p0;
  logic [WIDTH-1:0] r_p0;
  logic             c_p0;

  // ---- stage p0: operand mux, adder, logic unit, result select ----

  // Map each arithmetic op onto a single x + y + cin addition
  always_comb begin
    x_p0 = a;
    y_p0 = '0;
    unique case (op)
      OP_INC:  begin x_p0 = a;  y_p0 = '0;  end
      OP_NEG:  begin x_p0 = ~a; y_p0 = ONE; end
      OP_ADD:  begin x_p0 = a;  y_p0 = b;   end
      OP_INC1: begin x_p0 = a;  y_p0 = ONE; end
      default: begin x_p0 = a;  y_p0 = '0;  end
    endcase
  end

`ifdef ALU_OVF_EN
  logic cmsb_p0;
  logic v_p0;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (x_p0),
    .y    (y_p0),
    .ci   (cin),
    .sum  (sum_p0),
    .cout (cout_p0),
    .cmsb (cmsb_p0)
  );
`else
  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (x_p0),
    .y    (y_p0),
    .ci   (cin),
    .sum  (sum_p0),
    .cout (cout_p0)
  );
`endif

  // Bitwise logic unit; cin plays no part here
  always_comb begin
    logic_p0 = '0;
    unique case (op)
      OP_AND:  logic_p0 = a & b;
      OP_OR:   logic_p0 = a | b;
      OP_XOR:  logic_p0 = a ^ b;
      OP_NOT:  logic_p0 = ~a;
      default: logic_p0 = '0;
    endcase
  end

  // Pick the group result; carry is only meaningful for arithmetic
  always_comb begin
    r_p0 = sum_p0;
    c_p0 = cout_p0;
    if (l == SEL_LOGIC) begin
      r_p0 = logic_p0;
      c_p0 = 1'b0;
    end
  end

`ifdef ALU_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB
  always_comb begin
    v_p0 = 1'b0;
    if (l == SEL_ARITH) begin
      v_p0 = cmsb_p0 ^ cout_p0;
    end
  end
`endif

  // ---- stage p1: output registers (flags derived from the same r) ----

  // Register result and flags together so they always describe one op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      z <= 1'b1;
      c <= 1'b0;
      s <= 1'b0;
    end else begin
      r <= r_p0;
      z <= zero_flag(r_p0);
      c <= c_p0;
      s <= sign_flag(r_p0);
    end
  end

`ifdef ALU_OVF_EN
  // Overflow flag register, cleared with the rest of the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
    end else begin
      v <= v_p0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core at WIDTH=4: directed literal vectors,
// an asynchronous reset check, and an exhaustive sweep compared every
// cycle against an arithmetic reference model.
module tb_alu_core;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   op;
  logic         l;
  logic [W-1:0] r;
  logic         z;
  logic         c;
  logic         s;
  logic         v_dut;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

`ifdef ALU_OVF_EN
  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .op(op), .l(l),
    .r(r), .z(z), .c(c), .s(s), .v(v_dut)
  );
`else
  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .op(op), .l(l),
    .r(r), .z(z), .c(c), .s(s)
  );
  assign v_dut = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         s;
    logic         v;
  } res_t;

  function automatic int sval(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Reference: evaluate the operation with integer arithmetic
  function automatic res_t model(input logic ll, input logic [1:0] o,
                                 input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci);
    res_t res;
    int ai, bi, ni, t, st;
    ai = int'(aa);
    bi = int'(bb);
    ni = MOD - 1 - ai;
    t = 0;
    st = 0;
    res.v = 1'b0;
    if (ll) begin
      case (o)
        2'd0: t = ai & bi;
        2'd1: t = ai | bi;
        2'd2: t = ai ^ bi;
        default: t = ni;
      endcase
      res.c = 1'b0;
    end else begin
      case (o)
        2'd0: begin t = ai + int'(ci);          st = sval(ai) + int'(ci);             end
        2'd1: begin t = ni + 1 + int'(ci);      st = sval(ni) + 1 + int'(ci);         end
        2'd2: begin t = ai + bi + int'(ci);     st = sval(ai) + sval(bi) + int'(ci);  end
        default: begin t = ai + 1 + int'(ci);   st = sval(ai) + 1 + int'(ci);         end
      endcase
      res.c = (t >= MOD);
      res.v = (st > HALF - 1) || (st < -HALF);
    end
    res.r = W'(t % MOD);
    res.z = (res.r == '0);
    res.s = res.r[W-1];
    return res;
  endfunction

  res_t exp_q;

  // Expected outputs follow the same clock/reset timing as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= '{r: '0, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0};
    else     exp_q <= model(l, op, a, b, cin);
  end

  task automatic check(input string name, input res_t act, input res_t req);
    checks++;
`ifndef ALU_OVF_EN
    act.v = 1'b0;
    req.v = 1'b0;
`endif
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got r=%h z=%b c=%b s=%b v=%b, expected r=%h z=%b c=%b s=%b v=%b",
               name, act.r, act.z, act.c, act.s, act.v, req.r, req.z, req.c, req.s, req.v);
    end
  endtask

  function automatic res_t dut_out();
    return '{r: r, z: z, c: c, s: s, v: v_dut};
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) check("model", dut_out(), exp_q);
  end

  task automatic drive(input logic ll, input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic ci);
    @(negedge clk);
    l = ll; op = o; a = aa; b = bb; cin = ci;
  endtask

  task automatic lit(input string name, input logic ll, input logic [1:0] o,
                     input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                     input logic [W-1:0] er, input logic ez, input logic ec,
                     input logic es, input logic ev);
    drive(ll, o, aa, bb, ci);
    @(posedge clk);
    #1;
    check(name, dut_out(), '{r: er, z: ez, c: ec, s: es, v: ev});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; op = 2'b00; l = 1'b0;
    #1;
    check("por", dut_out(), '{r: 4'h0, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    //   name       l     op     a     b     cin    r     z     c     s     v
    lit("add0",   1'b0, 2'b10, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("addovf", 1'b0, 2'b10, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    lit("neg3",   1'b0, 2'b01, 4'h3, 4'h0, 1'b0, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("neg0",   1'b0, 2'b01, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("inc1E",  1'b0, 2'b11, 4'hE, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("inc1F",  1'b0, 2'b11, 4'hF, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
    lit("incF",   1'b0, 2'b00, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    lit("and",    1'b1, 2'b00, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("or",     1'b1, 2'b01, 4'hC, 4'hA, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
    lit("xor",    1'b1, 2'b10, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("not",    1'b1, 2'b11, 4'hC, 4'hA, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    lit("add8",   1'b0, 2'b10, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between clock edges, held across edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async", dut_out(), '{r: 4'h0, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0});
    l = 1'b1; op = 2'b11; a = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold", dut_out(), '{r: 4'h0, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep checked by the every-cycle comparison
    for (int li = 0; li < 2; li++)
      for (int oi = 0; oi < 4; oi++)
        for (int ci = 0; ci < 2; ci++)
          for (int ai = 0; ai < MOD; ai++)
            for (int bi = 0; bi < MOD; bi++)
              drive(li[0], oi[1:0], ai[W-1:0], bi[W-1:0], ci[0]);

    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
